// File: rtl/alu_uart_ctrl.sv
// Serial command sequencer: collects A, B and opcode bytes from a UART receiver,
// drives the ALU, then sends the result byte. Optional macro CARRY_BYTE_EN adds a carry byte.
module alu_uart_ctrl #(
  parameter int ALU_W       = 8,
  parameter int OP_W        = 6,
  parameter int EXEC_CYCLES = 2,
  parameter int TIMEOUT     = 1000000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_done,
  input  logic                    tx_busy,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  output logic [ALU_W-1:0]        alu_a,
  output logic [ALU_W-1:0]        alu_b,
  output logic [OP_W-1:0]         alu_op,
  input  logic signed [ALU_W-1:0] alu_res,
  input  logic                    alu_carry,
  output logic                    busy,
  output logic                    err,
  output logic                    overrun
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES + 1) : 1;

  typedef enum logic [2:0] {S_A, S_B, S_OP, S_EXEC, S_TX, S_TXW, S_TXC} state_t;

  state_t             state, state_nx;
  logic [ALU_W-1:0]   a_nx, b_nx;
  logic [OP_W-1:0]    op_nx;
  logic [7:0]         txd_nx;
  logic               txs_nx, err_nx, ovr_nx, busy_nx;
  logic [TMR_W-1:0]   timer, timer_nx;
  logic [CNT_W-1:0]   exec_cnt, cnt_nx;
  logic               carry_q, carry_nx;
  logic               txw_first, first_nx;
  logic               timeout_hit;
`ifdef CARRY_BYTE_EN
  logic               carry_phase, phase_nx;
`endif

  function automatic logic [7:0] sext8(input logic signed [ALU_W-1:0] v);
    logic signed [7:0] w;
    w = v;
    return w;
  endfunction

  function automatic logic op_valid(input logic [7:0] b);
    logic [7:0] hi;
    hi = b >> OP_W;
    case (b)
      8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27: return (hi == 8'd0);
      default: return 1'b0;
    endcase
  endfunction

  assign timeout_hit = (TIMEOUT != 0) && (timer == TMR_W'(TIMEOUT));

  always_comb begin
    state_nx = state;
    a_nx     = alu_a;
    b_nx     = alu_b;
    op_nx    = alu_op;
    txd_nx   = tx_data;
    txs_nx   = 1'b0;
    err_nx   = 1'b0;
    ovr_nx   = 1'b0;
    cnt_nx   = exec_cnt;
    carry_nx = carry_q;
    first_nx = txw_first;
`ifdef CARRY_BYTE_EN
    phase_nx = carry_phase;
`endif
    case (state)
      S_A: begin
        if (rx_done) begin
          a_nx     = rx_data[ALU_W-1:0];
          state_nx = S_B;
        end
      end
      S_B: begin
        // A byte arriving on the timeout clock still counts
        if (rx_done) begin
          b_nx     = rx_data[ALU_W-1:0];
          state_nx = S_OP;
        end else if (timeout_hit) begin
          err_nx   = 1'b1;
          state_nx = S_A;
        end
      end
      S_OP: begin
        if (rx_done) begin
          if (op_valid(rx_data)) begin
            op_nx    = rx_data[OP_W-1:0];
            cnt_nx   = CNT_W'(EXEC_CYCLES);
            state_nx = S_EXEC;
          end else begin
            err_nx = 1'b1;
          end
        end else if (timeout_hit) begin
          err_nx   = 1'b1;
          state_nx = S_A;
        end
      end
      S_EXEC: begin
        cnt_nx = exec_cnt - 1'b1;
        if (exec_cnt == CNT_W'(1)) begin
          txd_nx   = sext8(alu_res);
          carry_nx = alu_carry;
          state_nx = S_TX;
`ifdef CARRY_BYTE_EN
          phase_nx = 1'b0;
`endif
        end
      end
      S_TX: begin
        if (!tx_busy) begin
          txs_nx   = 1'b1;
          first_nx = 1'b1;
          state_nx = S_TXW;
        end
      end
      S_TXW: begin
        // First cycle after tx_start is ignored: tx_busy may not have risen yet
        if (txw_first) begin
          first_nx = 1'b0;
        end else if (!tx_busy) begin
`ifdef CARRY_BYTE_EN
          state_nx = carry_phase ? S_A : S_TXC;
`else
          state_nx = S_A;
`endif
        end
      end
      S_TXC: begin
        txd_nx   = {7'b0, carry_q};
`ifdef CARRY_BYTE_EN
        phase_nx = 1'b1;
`endif
        state_nx = S_TX;
      end
      default: state_nx = S_A;
    endcase

    if (rx_done && (state == S_EXEC || state == S_TX || state == S_TXW || state == S_TXC))
      ovr_nx = 1'b1;

    if (state_nx != state || rx_done)
      timer_nx = '0;
    else if (state == S_B || state == S_OP)
      timer_nx = timer + 1'b1;
    else
      timer_nx = '0;

    busy_nx = (state_nx != S_A);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_A;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      err       <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
      timer     <= '0;
      exec_cnt  <= '0;
      carry_q   <= 1'b0;
      txw_first <= 1'b0;
`ifdef CARRY_BYTE_EN
      carry_phase <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      alu_a     <= a_nx;
      alu_b     <= b_nx;
      alu_op    <= op_nx;
      tx_data   <= txd_nx;
      tx_start  <= txs_nx;
      err       <= err_nx;
      overrun   <= ovr_nx;
      busy      <= busy_nx;
      timer     <= timer_nx;
      exec_cnt  <= cnt_nx;
      carry_q   <= carry_nx;
      txw_first <= first_nx;
`ifdef CARRY_BYTE_EN
      carry_phase <= phase_nx;
`endif
    end
  end

endmodule
